// File: rtl/dma_pkg.sv
// Shared definitions for the DMA controller: FSM state codes, register map, CTRL/STATUS bits.
package dma_pkg;

    typedef logic [2:0] dma_state_t;

    localparam dma_state_t StIdle    = 3'd0;
    localparam dma_state_t StReq     = 3'd1;
    localparam dma_state_t StWaitGnt = 3'd2;
    localparam dma_state_t StXferRd  = 3'd3;
    localparam dma_state_t StXferWr  = 3'd4;
    localparam dma_state_t StRearm   = 3'd5;
    localparam dma_state_t StDone    = 3'd6;

    localparam logic [2:0] RegSrcH = 3'd0;
    localparam logic [2:0] RegSrcL = 3'd1;
    localparam logic [2:0] RegDstH = 3'd2;
    localparam logic [2:0] RegDstL = 3'd3;
    localparam logic [2:0] RegLenH = 3'd4;
    localparam logic [2:0] RegLenL = 3'd5;
    localparam logic [2:0] RegFill = 3'd6;
    localparam logic [2:0] RegCtrl = 3'd7;

    // CTRL write bits
    localparam int unsigned CtrlStart   = 0;
    localparam int unsigned CtrlMode    = 1;
    localparam int unsigned CtrlIen     = 2;
    localparam int unsigned CtrlAbort   = 6;
    localparam int unsigned CtrlClrDone = 7;

    // STATUS read bits
    localparam int unsigned StatBusy = 0;
    localparam int unsigned StatMode = 1;
    localparam int unsigned StatIen  = 2;
    localparam int unsigned StatDone = 7;

endpackage

// File: rtl/dma_regfile.sv
// CPU-visible register file: write decode, read mux, live address/length counters, DONE/IRQ.
module dma_regfile
    import dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [2:0]  reg_addr,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    input  logic        busy_i,
    input  logic        step_i,
    input  logic        done_set_i,
    output logic [14:0] src_o,
    output logic [14:0] dst_o,
    output logic [15:0] len_o,
    output logic [7:0]  fill_o,
    output logic        mode_o,
    output logic        start_o,
    output logic        abort_o,
    output logic        irq_n
);

    logic [14:0] src_q, dst_q;
    logic [15:0] len_q;
    logic [7:0]  fill_q;
    logic        mode_q, ien_q, done_q;
    logic        ctrl_wr, done_clr;
    logic [7:0]  status;

    // CTRL strobes: START only when idle, ABORT only when busy; STATUS read clears DONE.
    always_comb begin
        ctrl_wr  = reg_wr && (reg_addr == RegCtrl);
        start_o  = ctrl_wr && !busy_i && reg_wdata[CtrlStart];
        abort_o  = ctrl_wr && busy_i && reg_wdata[CtrlAbort];
        done_clr = (ctrl_wr && !busy_i && reg_wdata[CtrlClrDone]) ||
                   (reg_rd && (reg_addr == RegCtrl));
    end

    // Register state: CPU writes when idle, counter stepping after each RAM write when busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            fill_q <= '0;
            mode_q <= 1'b0;
            ien_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (step_i) begin
                src_q <= src_q + 15'd1;
                dst_q <= dst_q + 15'd1;
                len_q <= len_q - 16'd1;
            end else if (reg_wr && !busy_i) begin
                case (reg_addr)
                    RegSrcH: src_q[14:8] <= reg_wdata[6:0];
                    RegSrcL: src_q[7:0]  <= reg_wdata;
                    RegDstH: dst_q[14:8] <= reg_wdata[6:0];
                    RegDstL: dst_q[7:0]  <= reg_wdata;
                    RegLenH: len_q[15:8] <= reg_wdata;
                    RegLenL: len_q[7:0]  <= reg_wdata;
                    RegFill: fill_q      <= reg_wdata;
                    default: begin
                        mode_q <= reg_wdata[CtrlMode];
                        ien_q  <= reg_wdata[CtrlIen];
                    end
                endcase
            end
            if (ctrl_wr && busy_i) begin
                ien_q <= reg_wdata[CtrlIen];
            end
            // Set wins over a same-cycle clear.
            if (done_set_i) begin
                done_q <= 1'b1;
            end else if (done_clr) begin
                done_q <= 1'b0;
            end
        end
    end

    // Combinational read mux; SRC/DST/LEN are the live counters.
    always_comb begin
        status           = 8'h00;
        status[StatBusy] = busy_i;
        status[StatMode] = mode_q;
        status[StatIen]  = ien_q;
        status[StatDone] = done_q;
        case (reg_addr)
            RegSrcH: reg_rdata = {1'b0, src_q[14:8]};
            RegSrcL: reg_rdata = src_q[7:0];
            RegDstH: reg_rdata = {1'b0, dst_q[14:8]};
            RegDstL: reg_rdata = dst_q[7:0];
            RegLenH: reg_rdata = len_q[15:8];
            RegLenL: reg_rdata = len_q[7:0];
            RegFill: reg_rdata = fill_q;
            default: reg_rdata = status;
        endcase
    end

    // Register outputs to the FSM and interrupt line.
    always_comb begin
        src_o  = src_q;
        dst_o  = dst_q;
        len_o  = len_q;
        fill_o = fill_q;
        mode_o = mode_q;
        irq_n  = ~(done_q & ien_q);
    end

endmodule

// File: rtl/dma_ctrl.sv
// DMA controller top: bus-request FSM, grant synchroniser, burst/rearm counters, RAM port drive.
module dma_ctrl
    import dma_pkg::*;
#(
    parameter int unsigned BURST_MAX    = 14,
    parameter int unsigned REARM_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [2:0]  reg_addr,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic        nDMABREQ,
    input  logic        ba,
    input  logic        bs,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_own,
    output logic        irq_n
);

    localparam int unsigned BurstW = $clog2(BURST_MAX + 1);
    localparam int unsigned RearmW = $clog2(REARM_CYCLES + 1);

    dma_state_t        state_q, state_d;
    logic [BurstW-1:0] burst_q, burst_d;
    logic [RearmW-1:0] rearm_q, rearm_d;
    logic              ba_meta_q, bs_meta_q, ba_sync_q, bs_sync_q;
    logic              gnt, busy, xfer, step, done_set, start, abort, mode;
    logic [14:0]       src, dst;
    logic [15:0]       len;
    logic [7:0]        fill;

    dma_regfile u_regfile (
        .clk        (clk),
        .reset      (reset),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .busy_i     (busy),
        .step_i     (step),
        .done_set_i (done_set),
        .src_o      (src),
        .dst_o      (dst),
        .len_o      (len),
        .fill_o     (fill),
        .mode_o     (mode),
        .start_o    (start),
        .abort_o    (abort),
        .irq_n      (irq_n)
    );

    // Two-flop synchronisers on the CPU bus status lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ba_meta_q <= 1'b0;
            bs_meta_q <= 1'b0;
            ba_sync_q <= 1'b0;
            bs_sync_q <= 1'b0;
        end else begin
            ba_meta_q <= ba;
            bs_meta_q <= bs;
            ba_sync_q <= ba_meta_q;
            bs_sync_q <= bs_meta_q;
        end
    end

    // FSM and counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            burst_q <= '0;
            rearm_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            rearm_q <= rearm_d;
        end
    end

    // Next-state: request bus, move bytes while granted, rearm between bursts, honour abort.
    always_comb begin
        gnt      = ba_sync_q & bs_sync_q;
        state_d  = state_q;
        burst_d  = burst_q;
        rearm_d  = rearm_q;
        step     = 1'b0;
        done_set = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    if (len == 16'd0) begin
                        done_set = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                burst_d = '0;
                state_d = abort ? StIdle : StWaitGnt;
            end
            StWaitGnt: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (gnt) begin
                    state_d = mode ? StXferWr : StXferRd;
                end
            end
            StXferRd: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (!gnt) begin
                    state_d = StReq;
                end else begin
                    state_d = StXferWr;
                end
            end
            StXferWr: begin
                if (!gnt) begin
                    // Lost grant: the paired read is redone after re-grant.
                    state_d = abort ? StIdle : StReq;
                end else begin
                    step    = 1'b1;
                    burst_d = burst_q + BurstW'(1);
                    if (abort) begin
                        state_d = StIdle;
                    end else if (len == 16'd1) begin
                        done_set = 1'b1;
                        state_d  = StDone;
                    end else if (burst_q == BurstW'(BURST_MAX - 1)) begin
                        rearm_d = '0;
                        state_d = StRearm;
                    end else begin
                        state_d = mode ? StXferWr : StXferRd;
                    end
                end
            end
            StRearm: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (rearm_q == RearmW'(REARM_CYCLES - 1)) begin
                    state_d = StReq;
                end else begin
                    rearm_d = rearm_q + RearmW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus request and RAM port drive; all RAM strobes are gated by the synced grant.
    always_comb begin
        busy      = (state_q != StIdle) && (state_q != StDone);
        xfer      = (state_q == StXferRd) || (state_q == StXferWr);
        mem_own   = xfer && gnt;
        mem_we    = (state_q == StXferWr) && gnt;
        mem_addr  = mem_own ? ((state_q == StXferRd) ? src : dst) : 15'd0;
        mem_wdata = mem_we ? (mode ? fill : mem_rdata) : 8'h00;
        nDMABREQ  = !((state_q == StReq) || (state_q == StWaitGnt) || xfer);
    end

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl: RAM and mc6809 grant model, write/burst monitor, linear test steps.
module tb_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_wr = 1'b0;
    logic        reg_rd = 1'b0;
    logic [2:0]  reg_addr = 3'd0;
    logic [7:0]  reg_wdata = 8'h00;
    logic [7:0]  reg_rdata;
    logic        nDMABREQ;
    logic        ba = 1'b0;
    logic        bs = 1'b0;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_own;
    logic        irq_n;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  ram [0:32767];
    logic [14:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          bursts_q[$];
    int          runs_q[$];
    int          wr_cnt = 0, rd_cnt = 0, burst_wr = 0, high_run = 0, low_cnt = 0;
    int          gnt_delay = 3;
    int          drop_at = -1;
    bit          prev_req = 1'b1, seen_low = 1'b0, low_seen = 1'b0;
    logic [7:0]  rv;
    int          saved;

    dma_ctrl #(.BURST_MAX(14), .REARM_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .nDMABREQ  (nDMABREQ),
        .ba        (ba),
        .bs        (bs),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_own   (mem_own),
        .irq_n     (irq_n)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] src_byte(input int i);
        logic [7:0] b;
        b = 8'(i * 29);
        return b ^ 8'h3C;
    endfunction

    // RAM, write/read log, burst monitor and CPU grant model, all mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            ram[mem_addr] = mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_cnt++;
            burst_wr++;
        end else if (mem_own) begin
            mem_rdata = ram[mem_addr];
            rd_cnt++;
        end
        if (!nDMABREQ) low_seen = 1'b1;
        if (prev_req && !nDMABREQ) begin
            if (seen_low) runs_q.push_back(high_run);
            seen_low = 1'b1;
            burst_wr = 0;
        end
        if (!prev_req && nDMABREQ) bursts_q.push_back(burst_wr);
        high_run = nDMABREQ ? high_run + 1 : 0;
        prev_req = nDMABREQ;
        if (nDMABREQ) begin
            ba = 1'b0; bs = 1'b0; low_cnt = 0;
        end else if (drop_at >= 0 && wr_cnt == drop_at) begin
            ba = 1'b0; bs = 1'b0; low_cnt = 0; drop_at = -1;
        end else begin
            low_cnt++;
            if (low_cnt >= gnt_delay) begin
                ba = 1'b1; bs = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        @(posedge clk); #1;
        reg_wr = 1'b0;
    endtask

    task automatic reg_peek(input logic [2:0] a, output logic [7:0] d);
        reg_addr = a;
        #1;
        d = reg_rdata;
    endtask

    task automatic setup(input logic [14:0] s, input logic [14:0] d, input logic [15:0] n,
                         input logic [7:0] f);
        reg_write(3'd0, {1'b0, s[14:8]});
        reg_write(3'd1, s[7:0]);
        reg_write(3'd2, {1'b0, d[14:8]});
        reg_write(3'd3, d[7:0]);
        reg_write(3'd4, n[15:8]);
        reg_write(3'd5, n[7:0]);
        reg_write(3'd6, f);
    endtask

    task automatic clear_mon();
        wr_addr_q.delete(); wr_data_q.delete(); bursts_q.delete(); runs_q.delete();
        wr_cnt = 0; rd_cnt = 0; burst_wr = 0; seen_low = 1'b0; low_seen = 1'b0; drop_at = -1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic [7:0] st;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            reg_peek(3'd7, st);
            if (!st[0]) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle"}, 32'(ok), 32'd1);
        @(negedge clk); @(posedge clk); #1;
    endtask

    task automatic check_writes(input string tag, input logic [14:0] base, input int n,
                                input bit fill, input logic [7:0] fv);
        check({tag, "_count"}, 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(15'(base + 15'(i))));
            check($sformatf("%s_data%0d", tag, i), 32'(wr_data_q[i]),
                  32'(fill ? fv : src_byte(i)));
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
        for (int i = 0; i < 32; i++) ram[15'h1000 + i] = src_byte(i);

        // Reset state
        #2;
        check("rst_breq", 32'(nDMABREQ), 32'd1);
        check("rst_own", 32'(mem_own), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_irq", 32'(irq_n), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            reg_peek(3'(a), rv);
            check($sformatf("rst_reg%0d", a), 32'(rv), 32'd0);
        end

        // Copy 5 bytes 0x1000 -> 0x2000 with IEN
        setup(15'h1000, 15'h2000, 16'd5, 8'h00);
        clear_mon();
        reg_write(3'd7, 8'h05);
        wait_idle("copy5", 300);
        check_writes("copy5", 15'h2000, 5, 1'b0, 8'h00);
        check("copy5_reads", 32'(rd_cnt), 32'd5);
        reg_peek(3'd7, rv); check("copy5_status", 32'(rv), 32'h84);
        check("copy5_irq", 32'(irq_n), 32'd0);
        reg_peek(3'd0, rv); check("copy5_srch", 32'(rv), 32'h10);
        reg_peek(3'd1, rv); check("copy5_srcl", 32'(rv), 32'h05);
        reg_peek(3'd3, rv); check("copy5_dstl", 32'(rv), 32'h05);
        reg_peek(3'd5, rv); check("copy5_len", 32'(rv), 32'h00);
        reg_rd = 1'b1; reg_addr = 3'd7; @(posedge clk); #1; reg_rd = 1'b0;
        reg_peek(3'd7, rv); check("rdclr_status", 32'(rv), 32'h04);
        check("rdclr_irq", 32'(irq_n), 32'd1);

        // Fill 4 bytes across the 15-bit wrap
        setup(15'h0000, 15'h7FFE, 16'd4, 8'hA5);
        clear_mon();
        reg_write(3'd7, 8'h03);
        wait_idle("fill4", 300);
        wr_addr_q[2] = wr_addr_q[2];
        check("fill4_count", 32'(wr_addr_q.size()), 32'd4);
        if (wr_addr_q.size() == 4) begin
            check("fill4_a0", 32'(wr_addr_q[0]), 32'h7FFE);
            check("fill4_a1", 32'(wr_addr_q[1]), 32'h7FFF);
            check("fill4_a2", 32'(wr_addr_q[2]), 32'h0000);
            check("fill4_a3", 32'(wr_addr_q[3]), 32'h0001);
            for (int i = 0; i < 4; i++) check($sformatf("fill4_d%0d", i), 32'(wr_data_q[i]), 32'hA5);
        end
        reg_peek(3'd4, rv); check("fill4_lenh", 32'(rv), 32'h00);
        reg_peek(3'd5, rv); check("fill4_lenl", 32'(rv), 32'h00);
        reg_peek(3'd2, rv); check("fill4_dsth", 32'(rv), 32'h00);
        reg_peek(3'd3, rv); check("fill4_dstl", 32'(rv), 32'h02);
        reg_peek(3'd7, rv); check("fill4_status", 32'(rv), 32'h82);
        check("fill4_irq", 32'(irq_n), 32'd1);
        reg_write(3'd7, 8'h80);
        reg_peek(3'd7, rv); check("clrdone_status", 32'(rv), 32'h00);

        // Copy 30 bytes: bursts 14/14/2 with 16-cycle gaps
        setup(15'h1000, 15'h3000, 16'd30, 8'h00);
        clear_mon();
        reg_write(3'd7, 8'h01);
        wait_idle("copy30", 2000);
        check_writes("copy30", 15'h3000, 30, 1'b0, 8'h00);
        check("copy30_nbursts", 32'(bursts_q.size()), 32'd3);
        check("copy30_nruns", 32'(runs_q.size()), 32'd2);
        if (bursts_q.size() == 3) begin
            check("copy30_b0", 32'(bursts_q[0]), 32'd14);
            check("copy30_b1", 32'(bursts_q[1]), 32'd14);
            check("copy30_b2", 32'(bursts_q[2]), 32'd2);
        end
        if (runs_q.size() == 2) begin
            check("copy30_gap0", 32'(runs_q[0]), 32'd16);
            check("copy30_gap1", 32'(runs_q[1]), 32'd16);
        end
        reg_peek(3'd7, rv); check("copy30_status", 32'(rv), 32'h80);
        reg_write(3'd7, 8'h80);

        // Grant dropped after the 2nd write: 3rd read is issued, write suppressed, read redone
        setup(15'h1000, 15'h4000, 16'd5, 8'h00);
        clear_mon();
        drop_at = 2;
        reg_write(3'd7, 8'h01);
        wait_idle("gdrop", 500);
        check_writes("gdrop", 15'h4000, 5, 1'b0, 8'h00);
        check("gdrop_reads", 32'(rd_cnt), 32'd6);
        reg_peek(3'd7, rv); check("gdrop_status", 32'(rv), 32'h80);
        reg_write(3'd7, 8'h80);

        // START with LEN = 0: DONE on the next clock, no bus request
        setup(15'h1000, 15'h4000, 16'd0, 8'h00);
        clear_mon();
        reg_write(3'd7, 8'h01);
        reg_peek(3'd7, rv); check("len0_status", 32'(rv), 32'h80);
        repeat (20) @(posedge clk);
        #1;
        check("len0_noreq", 32'(low_seen), 32'd0);
        reg_write(3'd7, 8'h80);

        // ABORT after 3 of 10 bytes, issued during the 4th read
        setup(15'h1000, 15'h5000, 16'd10, 8'h00);
        clear_mon();
        reg_write(3'd7, 8'h01);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (wr_cnt >= 3) break;
        end
        check("abort_reach3", 32'(wr_cnt >= 3), 32'd1);
        #1;
        reg_write(3'd7, 8'h40);
        repeat (3) @(posedge clk);
        #1;
        check_writes("abort", 15'h5000, 3, 1'b0, 8'h00);
        reg_peek(3'd4, rv); check("abort_lenh", 32'(rv), 32'h00);
        reg_peek(3'd5, rv); check("abort_lenl", 32'(rv), 32'h07);
        reg_peek(3'd1, rv); check("abort_srcl", 32'(rv), 32'h03);
        reg_peek(3'd7, rv); check("abort_status", 32'(rv), 32'h00);
        check("abort_breq", 32'(nDMABREQ), 32'd1);

        // Reset pulse mid-burst
        setup(15'h1000, 15'h6000, 16'd20, 8'h00);
        clear_mon();
        reg_write(3'd7, 8'h05);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (wr_cnt >= 2) break;
        end
        #1;
        check("mrst_own_before", 32'(mem_own), 32'd1);
        check("mrst_breq_before", 32'(nDMABREQ), 32'd0);
        reset = 1'b1;
        #1;
        check("mrst_breq", 32'(nDMABREQ), 32'd1);
        check("mrst_own", 32'(mem_own), 32'd0);
        check("mrst_we", 32'(mem_we), 32'd0);
        check("mrst_addr", 32'(mem_addr), 32'd0);
        saved = wr_cnt;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mrst_nowrites", 32'(wr_cnt), 32'(saved));
        check("mrst_irq", 32'(irq_n), 32'd1);
        for (int a = 0; a < 8; a++) begin
            reg_peek(3'(a), rv);
            check($sformatf("mrst_reg%0d", a), 32'(rv), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 Parameter BURST_MAX, 14, maximum bytes moved per bus grant before nDMABREQ is released.
REQ-002 Parameter REARM_CYCLES, 16, clk cycles nDMABREQ stays high between bursts.
REQ-003 clk  in  1  single clock; all state on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 reg_wr  in  1  one-clk register write strobe from CPU decode.
REQ-006 reg_rd  in  1  one-clk register read strobe (side effects only).
REQ-007 reg_addr  in  3  register select.
REQ-008 reg_wdata  in  8  register write data.
REQ-009 reg_rdata  out  8  register read data, combinational from reg_addr.
REQ-010 nDMABREQ  out  1  active-low DMA/bus request to mc6809.
REQ-011 ba, bs  in  1 each  CPU bus status; grant = ba & bs after 2-flop sync.
REQ-012 mem_addr  out  15  RAM address while granted.
REQ-013 mem_we  out  1  RAM write enable, one clk per byte.
REQ-014 mem_wdata  out  8  RAM write data.
REQ-015 mem_rdata  in  8  RAM read data, valid one clk after mem_addr with mem_we=0.
REQ-016 mem_own  out  1  high while block drives RAM port (top-level mux select).
REQ-017 irq_n  out  1  active-low completion interrupt.

Function
REQ-018 Registers: 0 SRC_H, 1 SRC_L, 2 DST_H, 3 DST_L, 4 LEN_H, 5 LEN_L, 6 FILL, 7 CTRL/STATUS; SRC_H/DST_H bit7 ignored (15-bit addresses).
REQ-019 CTRL write: bit0 START, bit1 MODE (0 copy, 1 fill), bit2 IEN, bit6 ABORT, bit7 CLR_DONE; STATUS read: bit0 BUSY, bit1 MODE, bit2 IEN, bit7 DONE, others 0.
REQ-020 Writes to registers 0-6 while BUSY are ignored; CTRL write while BUSY honours only ABORT and IEN.
REQ-021 States: IDLE, REQ, WAIT_GNT, XFER_RD, XFER_WR, REARM, DONE.
REQ-022 IDLE -> REQ on START with LEN != 0; START with LEN == 0 sets DONE directly, no bus request.
REQ-023 REQ drives nDMABREQ low; WAIT_GNT holds until synced grant, then mem_own=1.
REQ-024 Copy: XFER_RD presents SRC (we=0); XFER_WR next clk writes mem_rdata to DST; 2 clk/byte.
REQ-025 Fill: XFER_WR only, writes FILL to DST; 1 clk/byte.
REQ-026 After each write: SRC, DST increment mod 2^15 (0x7FFF -> 0x0000); LEN decrements; burst counter increments.
REQ-027 LEN reaching 0 -> DONE: nDMABREQ high, mem_own=0, DONE=1, BUSY=0, then IDLE.
REQ-028 Burst counter == BURST_MAX with LEN != 0 -> REARM: nDMABREQ high, mem_own=0 for REARM_CYCLES, then REQ.
REQ-029 Grant loss mid-burst: no further RAM access that clk, mem_own=0, return to REQ; a copy read without its write is reissued.
REQ-030 ABORT: finish current XFER_WR, release bus, BUSY=0, DONE unchanged; live SRC/DST/LEN remain readable.
REQ-031 irq_n = ~(DONE & IEN); DONE cleared by CLR_DONE write or reg_rd of STATUS; set and clear in same clk -> set wins.
REQ-032 BUSY=1 from START acceptance to entry of IDLE; reading SRC/DST/LEN while BUSY returns live values.

Reset
REQ-033 reset: state IDLE, all registers 0x00, nDMABREQ=1, mem_we=0, mem_own=0, mem_addr=0, mem_wdata=0, irq_n=1, sync flops 0.
REQ-034 reset asserted mid-transfer: bus released same instant, no further mem_we; pending byte lost.

Structure
REQ-035 Shared package dma_pkg: state enum, register offsets 0-7, CTRL/STATUS bit positions.
REQ-036 One sub-module dma_regfile (register decode, read mux, DONE/IRQ logic); FSM and counters in dma_ctrl.

Verification
REQ-037 Copy SRC=0x1000 DST=0x2000 LEN=5, grant after 3 clk -> 5 writes at 0x2000-0x2004 matching source, DONE=1, irq_n=0 if IEN.
REQ-038 Fill FILL=0xA5 DST=0x7FFE LEN=4 -> writes 0x7FFE, 0x7FFF, 0x0000, 0x0001; LEN reads 0.
REQ-039 Copy LEN=30, BURST_MAX=14 -> bursts of 14,14,2; nDMABREQ high exactly REARM_CYCLES clk between bursts.
REQ-040 Grant dropped between XFER_RD and XFER_WR -> no write; read reissued after re-grant; data correct.
REQ-041 START with LEN=0 -> DONE next clk, nDMABREQ never low; ABORT after 3 of 10 bytes -> LEN=7, BUSY=0.
REQ-042 reset pulse mid-burst -> nDMABREQ=1, mem_own=0 asynchronously; all registers read 0x00.
